// File: rtl/poly_key_tone_gen_pkg.sv
// Shared constants for the polyphonic key tone generator: note table, FSM states, octave width.
// Latency: none (package only).
// Backpressure: none (package only).
package tone_pkg;

    localparam int OCT_W  = 2;
    localparam int BASE_W = 15;

    // Half-periods in core clocks for C6..C7 at 50 MHz, index 0 = lowest pitch key
    localparam logic [BASE_W-1:0] BASE_HALF [0:7] = '{
        15'd23889, 15'd21283, 15'd18961, 15'd17897,
        15'd15944, 15'd14205, 15'd12655, 15'd11945
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Table entry shifted down by the octave select; the widest result is 3 bits above the table
    function automatic logic [BASE_W+2:0] shifted_half(input logic [2:0] idx,
                                                       input logic [OCT_W-1:0] oct_sel);
        shifted_half = {3'b000, BASE_HALF[idx]} << oct_sel;
    endfunction

endpackage

// File: rtl/poly_key_tone_gen_tone_divider.sv
// Half-period counter driving a 50% square wave; new half-period is adopted only at a toggle.
// Latency: start/clear act on the next edge; first toggle comes i_start_half cycles after start.
// Backpressure: none; free-running while neither clear nor start is asserted.
module tone_divider #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_start_half,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_tone
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic             r_tone;
    logic             w_wrap;

    assign w_wrap = (r_cnt == r_half - CNT_W'(1));
    assign o_tone = r_tone;

    // Clear silences at once; start arms a fresh period; otherwise count and reload only at a toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_half <= '0;
            r_tone <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
            r_half <= i_start_half;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
            r_half <= i_target;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/poly_key_tone_gen.sv
// Scans keys on a slow tick, plays the lowest pressed key as a square wave with sustain; optional POLY_KEY_DEBOUNCE_EN.
// Latency: 2 sync cycles + wait for next scan tick (+2 ticks with POLY_KEY_DEBOUNCE_EN); enable=0 silences next cycle.
// Backpressure: none; keys are level inputs sampled only on scan ticks.
module poly_key_tone_gen
    import tone_pkg::*;
#(
    parameter int NUM_KEYS      = 8,
    parameter int CNT_W         = 18,
    parameter int SCAN_W        = 16,
    parameter int SUSTAIN_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [OCT_W-1:0]    oct,
    input  logic                enable,
    output logic                tone_o,
    output logic [2:0]          note_idx,
    output logic                playing
);

    localparam int SUS_W = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS + 1) : 1;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [SCAN_W-1:0]   r_presc;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_keys;
    logic                w_any;
    logic [2:0]          w_sel;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_note;
    logic [2:0]          w_note_nxt;
    logic [SUS_W-1:0]    r_sus;
    logic [SUS_W-1:0]    w_sus_nxt;

    logic                w_clear;
    logic                w_start;
    logic [CNT_W-1:0]    w_start_half;
    logic [CNT_W-1:0]    w_target;

    // Two-flop synchroniser for the asynchronous key levels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running scan prescaler; the tick is the cycle before it wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + SCAN_W'(1);
        end
    end

    assign w_tick = &r_presc;

`ifdef POLY_KEY_DEBOUNCE_EN
    logic [NUM_KEYS-1:0] r_hist1;
    logic [NUM_KEYS-1:0] r_hist2;
    logic [NUM_KEYS-1:0] r_acc;
    logic                w_stable;

    // A vector seen on this tick and the two before it replaces the accepted state
    assign w_stable = (r_sync2 == r_hist1) && (r_hist1 == r_hist2);
    assign w_keys   = w_stable ? r_sync2 : r_acc;

    // Tick-rate history of raw samples and the accepted key vector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist1 <= '0;
            r_hist2 <= '0;
            r_acc   <= '0;
        end else if (w_tick) begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_acc   <= w_keys;
        end
    end
`else
    assign w_keys = r_sync2;
`endif

    assign w_any = |w_keys;

    // Lowest pressed index wins: scan from the top so the lowest hit is written last
    always_comb begin
        w_sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_keys[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // FSM state, sounding note and sustain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_note  <= '0;
            r_sus   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_note  <= w_note_nxt;
            r_sus   <= w_sus_nxt;
        end
    end

    // Next-state: disable forces IDLE at any cycle, otherwise transitions happen on ticks only
    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_sus_nxt   = r_sus;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_state_nxt = PLAY;
                        w_note_nxt  = w_sel;
                    end
                end
                PLAY: begin
                    if (w_any) begin
                        w_note_nxt = w_sel;
                    end else if (SUSTAIN_TICKS == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = RELEASE;
                        w_sus_nxt   = SUS_W'(SUSTAIN_TICKS);
                    end
                end
                RELEASE: begin
                    if (w_any) begin
                        w_state_nxt = PLAY;
                        w_note_nxt  = w_sel;
                    end else if (r_sus <= SUS_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_sus_nxt   = '0;
                    end else begin
                        w_sus_nxt   = r_sus - SUS_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A fresh note takes its pitch at once; a running note only adopts a new pitch at a toggle
    assign w_clear      = (w_state_nxt == IDLE);
    assign w_start      = (r_state == IDLE) && (w_state_nxt == PLAY);
    assign w_start_half = CNT_W'(shifted_half(w_note_nxt, oct));
    assign w_target     = CNT_W'(shifted_half(r_note, oct));

    tone_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_start     (w_start),
        .i_start_half(w_start_half),
        .i_target    (w_target),
        .o_tone      (tone_o)
    );

    assign note_idx = r_note;
    assign playing  = (r_state != IDLE);

endmodule

// File: tb/tb_poly_key_tone_gen.sv
// Bench for poly_key_tone_gen: event-time reference model compared every cycle plus literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_poly_key_tone_gen;

    localparam int NK = 8;
    localparam int CW = 18;
    localparam int SW = 4;
    localparam int ST = 2;
    localparam int TICK_PERIOD = 1 << SW;
    localparam int TBL [8] = '{23889, 21283, 18961, 17897, 15944, 14205, 12655, 11945};
    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_REL  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys;
    logic [1:0]    oct;
    logic          enable;
    logic          tone_o;
    logic [2:0]    note_idx;
    logic          playing;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: state as plain integers, tone as scheduled toggle times
    int       m_state = 0;
    int       m_note  = 0;
    int       m_sus   = 0;
    int       m_tone  = 0;
    int       m_pre   = 0;
    int       m_half_sched = 0;
    longint   now     = 0;
    longint   m_next  = 0;
    logic [7:0] m_s1  = '0;
    logic [7:0] m_s2  = '0;
`ifdef POLY_KEY_DEBOUNCE_EN
    logic [7:0] m_h1  = '0;
    logic [7:0] m_h2  = '0;
    logic [7:0] m_acc = '0;
`endif

    always #10 clk = ~clk;

    poly_key_tone_gen #(
        .NUM_KEYS     (NK),
        .CNT_W        (CW),
        .SCAN_W       (SW),
        .SUSTAIN_TICKS(ST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .keys    (keys),
        .oct     (oct),
        .enable  (enable),
        .tone_o  (tone_o),
        .note_idx(note_idx),
        .playing (playing)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, now);
        end
    endtask

    function automatic int lowest(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [7:0] smp;
        bit         tick;
        bit         any;
        int         ns, nn, nsus, sel;
        if (reset) begin
            m_state = S_IDLE; m_note = 0; m_sus = 0; m_tone = 0; m_pre = 0;
            m_s1 = '0; m_s2 = '0;
`ifdef POLY_KEY_DEBOUNCE_EN
            m_h1 = '0; m_h2 = '0; m_acc = '0;
`endif
        end else begin
            tick = (m_pre == TICK_PERIOD - 1);
            smp  = m_s2;
`ifdef POLY_KEY_DEBOUNCE_EN
            if (tick) begin
                if (m_s2 == m_h1 && m_h1 == m_h2) m_acc = m_s2;
                m_h2 = m_h1;
                m_h1 = m_s2;
            end
            smp = m_acc;
`endif
            any  = (smp != 8'd0);
            sel  = lowest(smp);
            ns   = m_state;
            nn   = m_note;
            nsus = m_sus;
            if (!enable) begin
                ns = S_IDLE;
            end else if (tick) begin
                if (any) begin
                    ns = S_PLAY;
                    nn = sel;
                end else if (m_state == S_PLAY) begin
                    ns   = S_REL;
                    nsus = ST;
                end else if (m_state == S_REL) begin
                    nsus = m_sus - 1;
                    if (nsus <= 0) begin
                        nsus = 0;
                        ns   = S_IDLE;
                    end
                end
            end
            if (ns == S_IDLE) begin
                m_tone = 0;
            end else if (m_state == S_IDLE) begin
                m_tone       = 0;
                m_half_sched = TBL[nn] << oct;
                m_next       = now + m_half_sched;
            end else if (now == m_next) begin
                m_tone       = 1 - m_tone;
                m_half_sched = TBL[m_note] << oct;
                m_next       = now + m_half_sched;
            end
            m_state = ns;
            m_note  = nn;
            m_sus   = nsus;
            m_pre   = (m_pre + 1) % TICK_PERIOD;
            m_s2    = m_s1;
            m_s1    = keys;
        end
        now++;
    endtask

    // Model advances on the same edges the DUT sees
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_tone", tone_o, m_tone);
                check("cyc_note", note_idx, m_note);
                check("cyc_playing", playing, (m_state != S_IDLE) ? 1 : 0);
            end
        end
    end

    task automatic wait_play(input string name, input logic want, input int budget);
        int n = 0;
        while (playing !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, playing, want);
    endtask

    task automatic wait_toggle(input string name, input int budget, output int n);
        logic prev;
        prev = tone_o;
        n = 0;
        while (tone_o === prev && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (tone_o !== prev) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int hold;
        reset  = 1'b1;
        keys   = '0;
        oct    = 2'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Quiet after reset with no keys
        repeat (100) @(negedge clk);
        check("rst_tone", tone_o, 0);
        check("rst_playing", playing, 0);
        check("rst_note", note_idx, 0);

        // Key 2 at the top octave
        keys = 8'b0000_0100;
        wait_play("key2_play", 1'b1, 80);
        check("key2_note", note_idx, 2);
        wait_toggle("key2_tog1", 20000, n);

        // Lower key joins mid-period: note retargets, pitch waits for the boundary
        repeat (50) @(negedge clk);
        keys = 8'b0010_0110;
        repeat (80) @(negedge clk);
        check("multi_note", note_idx, 1);
        wait_toggle("key2_tog2", 20000, n);
        check("retarget_at_boundary", 130 + n, 18961);

        // Key 0, then octave drop mid-period: running period finishes first
        keys = 8'b0000_0001;
        repeat (1000) @(negedge clk);
        oct = 2'd2;
        wait_toggle("oct_tog", 23000, n);
        check("oct_boundary", 1000 + n, 21283);
        check("model_oct_half", m_half_sched, 95556);
        check("key0_note", note_idx, 0);
        repeat (3000) @(negedge clk);

        // Release: sustain for two ticks, then silence
        keys = '0;
        oct  = 2'd0;
        n = 0;
        while (m_state != S_REL && n < 120) begin
            @(negedge clk);
            n++;
        end
        check("release_playing", playing, 1);
        n = 0;
        while (playing !== 1'b0 && n < 120) begin
            @(negedge clk);
            n++;
        end
        check("sustain_len", n, 2 * TICK_PERIOD);
        check("idle_tone", tone_o, 0);

`ifndef POLY_KEY_DEBOUNCE_EN
        // Re-press during sustain returns to PLAY
        keys = 8'b0010_0000;
        wait_play("key5_play", 1'b1, 80);
        keys = '0;
        n = 0;
        while (m_state != S_REL && n < 80) begin
            @(negedge clk);
            n++;
        end
        keys = 8'b0010_0000;
        repeat (40) @(negedge clk);
        check("repress_playing", playing, 1);
        check("repress_note", note_idx, 5);
`endif

        // Enable drop silences on the next cycle
        keys = 8'b0000_1000;
        wait_play("key3_play", 1'b1, 120);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_tone", tone_o, 0);
        check("dis_playing", playing, 0);
        enable = 1'b1;
        wait_play("reen_play", 1'b1, 120);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tone", tone_o, 0);
        check("midrst_playing", playing, 0);
        check("midrst_note", note_idx, 0);
        reset = 1'b0;

        // Random key/octave/enable traffic with occasional reset pulses
        for (int it = 0; it < 250; it++) begin
            keys   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) keys = '0;
            oct    = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 31) == 0);
            hold   = $urandom_range(1, 48);
            repeat (hold) @(negedge clk);
            reset  = 1'b0;
        end

`ifdef POLY_KEY_DEBOUNCE_EN
        // One-tick glitch is rejected, a steady press is accepted
        keys   = '0;
        enable = 1'b1;
        repeat (200) @(negedge clk);
        keys = 8'b0000_0001;
        repeat (TICK_PERIOD) @(negedge clk);
        keys = '0;
        repeat (100) @(negedge clk);
        check("glitch_reject", playing, 0);
        keys = 8'b0000_0001;
        wait_play("held_accept", 1'b1, 5 * TICK_PERIOD);
`endif

        keys = '0;
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
